adc_capture_sequencer: RTL and testbench

- Run controller between the UART link and the Giraffe sub-ADC.
- On a start command byte from uart_rx it pulses the ADC reset, then enables conversion.
- It captures NUM_Sampled conversion codes on synchronized adc_ack rising edges and buffers them in an internal FIFO.
- It streams the codes to uart_tx one byte per sample, then closes the run with a status trailer byte.

---
 rtl/adc_capture_sequencer.sv | 167 ++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// Run controller between the UART link and the sub-ADC. A run goes through reset pulse,
// capture into a small FIFO, then streams the codes out over UART and ends with a status trailer.
module adc_capture_sequencer #(
  parameter int          NUM_bit     = 6,
  parameter int          NUM_Sampled = 1024,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          RST_CYCLES  = 8,
  parameter logic [7:0]  CMD_START   = 8'h55,
  parameter logic [7:0]  CMD_ABORT   = 8'hA5,
  parameter logic [7:0]  TRAILER_OK  = 8'hAA,
  parameter logic [7:0]  TRAILER_OVF = 8'hEE,
  localparam int         CW          = $clog2(NUM_Sampled + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [7:0]         uart_rdata,
  input  logic               uart_vld,
  output logic [7:0]         uart_wdata,
  output logic               uart_wreq,
  input  logic               uart_rdy,
  output logic               adc_rstn,
  output logic               adc_ena,
  input  logic               adc_ack,
  input  logic [NUM_bit-1:0] adc_dout,
  output logic               busy,
  output logic               overflow,
  output logic [CW-1:0]      cnt_captured,
  output logic [2:0]         state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_CAPTURE = 3'd2,
    S_DRAIN = 3'd3, S_TRAILER = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               wreq_q, wreq_d;
  logic [7:0]         wdata_q, wdata_d;
  // ack_q: [0] metastable stage, [1] synchronized, [2] previous synchronized
  logic [2:0]         ack_q, ack_d;
  logic [NUM_bit-1:0] dout_m_q, dout_m_d, dout_s_q, dout_s_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]      fill_q, fill_d;
  logic [NUM_bit-1:0] mem_q [FIFO_DEPTH];

  logic sample_ev, start_cmd, abort_cmd, fifo_empty, fifo_full, pop, take, push;

  always_comb begin
    sample_ev  = ack_q[1] & ~ack_q[2];
    start_cmd  = uart_vld && (uart_rdata == CMD_START) && (state_q == S_IDLE);
    abort_cmd  = uart_vld && (uart_rdata == CMD_ABORT) && (state_q != S_IDLE);
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == DW'(FIFO_DEPTH));
    // Pop only from what was stored before this cycle; a fresh push never bypasses.
    pop  = !fifo_empty && uart_rdy && !wreq_q && !abort_cmd &&
           ((state_q == S_CAPTURE) || (state_q == S_DRAIN));
    take = (state_q == S_CAPTURE) && sample_ev && (cnt_q < CW'(NUM_Sampled)) && !abort_cmd;
    push = take && (!fifo_full || pop);

    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wreq_d    = 1'b0;
    wdata_d   = wdata_q;
    ack_d     = {ack_q[1:0], adc_ack};
    dout_m_d  = adc_dout;
    dout_s_d  = dout_m_q;
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    fill_d    = fill_q + DW'(push) - DW'(pop);

    if (pop) begin
      wreq_d  = 1'b1;
      wdata_d = 8'(mem_q[rd_ptr_q]);
    end

    case (state_q)
      S_IDLE: if (start_cmd) begin
        state_d   = S_ARM;
        rst_cnt_d = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        fill_d    = '0;
      end
      S_ARM: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = S_CAPTURE;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_CAPTURE: if (take) begin
        cnt_d = cnt_q + 1'b1;
        if (!push) ovf_d = 1'b1;
        if (cnt_q == CW'(NUM_Sampled - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (fifo_empty && !wreq_q) state_d = S_TRAILER;
      S_TRAILER: if (uart_rdy && !wreq_q) begin
        wreq_d  = 1'b1;
        wdata_d = ovf_q ? TRAILER_OVF : TRAILER_OK;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_cmd) begin
      state_d  = S_IDLE;
      wreq_d   = 1'b0;
      wdata_d  = wdata_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      wreq_q    <= 1'b0;
      wdata_q   <= '0;
      ack_q     <= '0;
      dout_m_q  <= '0;
      dout_s_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      wreq_q    <= wreq_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      dout_m_q  <= dout_m_d;
      dout_s_q  <= dout_s_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dout_s_q;
  end

  assign adc_rstn     = (state_q != S_ARM);
  assign adc_ena      = (state_q == S_CAPTURE);
  assign busy         = (state_q != S_IDLE);
  assign overflow     = ovf_q;
  assign cnt_captured = cnt_q;
  assign state_o      = state_q;
  assign uart_wreq    = wreq_q;
  assign uart_wdata   = wdata_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench: clean run, overflow run, abort, async reset and ignored commands,
// with a byte log of everything requested on the UART transmit side.
module tb_adc_capture_sequencer;

  localparam int NB = 6;
  localparam int NS = 8;
  localparam int CW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [7:0]    uart_rdata = '0;
  logic          uart_vld = 1'b0;
  logic [7:0]    uart_wdata;
  logic          uart_wreq;
  logic          uart_rdy = 1'b1;
  logic          adc_rstn;
  logic          adc_ena;
  logic          adc_ack = 1'b0;
  logic [NB-1:0] adc_dout = '0;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] cnt_captured;
  logic [2:0]    state_o;

  adc_capture_sequencer #(
    .NUM_bit(NB), .NUM_Sampled(NS), .FIFO_DEPTH(4), .RST_CYCLES(8)
  ) dut (
    .clk(clk), .nrst(nrst), .uart_rdata(uart_rdata), .uart_vld(uart_vld),
    .uart_wdata(uart_wdata), .uart_wreq(uart_wreq), .uart_rdy(uart_rdy),
    .adc_rstn(adc_rstn), .adc_ena(adc_ena), .adc_ack(adc_ack), .adc_dout(adc_dout),
    .busy(busy), .overflow(overflow), .cnt_captured(cnt_captured), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] tx_q[$];
  int rstn_low = 0;
  int b2b = 0;
  logic prev_wreq = 1'b0;

  always @(negedge clk) begin
    if (nrst) begin
      if (uart_wreq) tx_q.push_back(uart_wdata);
      if (uart_wreq && prev_wreq) b2b++;
      if (!adc_rstn) rstn_low++;
    end
    prev_wreq = uart_wreq;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rdata = b;
    uart_vld   = 1'b1;
    @(negedge clk);
    uart_vld   = 1'b0;
  endtask

  task automatic adc_pulse(input logic [NB-1:0] code, input int gap);
    @(negedge clk);
    adc_dout = code;
    adc_ack  = 1'b1;
    repeat (4) @(negedge clk);
    adc_ack  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (state_o != s && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, state_o, s);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rstn"}, adc_rstn, 1);
    chk({tag, "_ena"}, adc_ena, 0);
    chk({tag, "_wreq"}, uart_wreq, 0);
    chk({tag, "_wdata"}, uart_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_cnt"}, cnt_captured, 0);
    chk({tag, "_state"}, state_o, 0);
  endtask

  initial begin
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run; also stray byte in IDLE and START during CAPTURE
    send_byte(8'h12);
    chk("idle_ignore_state", state_o, 0);
    chk("idle_ignore_busy", busy, 0);
    tx_q.delete();
    rstn_low = 0;
    b2b = 0;
    send_byte(8'h55);
    chk("arm_state", state_o, 1);
    wait_state(3'd2, 50, "to_capture");
    chk("arm_rstn_cycles", rstn_low, 8);
    for (int i = 0; i < NS; i++) begin
      adc_pulse(NB'(i), 36);
      if (i == 2) begin
        send_byte(8'h55);
        chk("start_in_capture_state", state_o, 2);
        chk("start_in_capture_cnt", cnt_captured, 3);
      end
    end
    wait_state(3'd0, 200, "clean_done");
    chk("clean_nbytes", tx_q.size(), 9);
    for (int i = 0; i < 9 && i < tx_q.size(); i++)
      chk($sformatf("clean_byte%0d", i), tx_q[i], (i < 8) ? i : 8'hAA);
    chk("clean_cnt", cnt_captured, 8);
    chk("clean_ovf", overflow, 0);
    chk("no_back_to_back", b2b, 0);

    // Overflow run: depth 4, transmitter stalled
    uart_rdy = 1'b0;
    send_byte(8'h55);
    tx_q.delete();
    wait_state(3'd2, 50, "ovf_to_capture");
    for (int i = 0; i < 6; i++) adc_pulse(NB'(10 + i), 16);
    chk("ovf_cnt6", cnt_captured, 6);
    chk("ovf_flag", overflow, 1);
    for (int i = 6; i < NS; i++) adc_pulse(NB'(10 + i), 16);
    chk("ovf_drain_state", state_o, 3);
    chk("ovf_stalled_nbytes", tx_q.size(), 0);
    uart_rdy = 1'b1;
    wait_state(3'd0, 200, "ovf_done");
    chk("ovf_nbytes", tx_q.size(), 5);
    for (int i = 0; i < 5 && i < tx_q.size(); i++)
      chk($sformatf("ovf_byte%0d", i), tx_q[i], (i < 4) ? 10 + i : 8'hEE);
    chk("ovf_hold", overflow, 1);

    // Abort after 3 samples
    send_byte(8'h55);
    chk("abort_run_ovf_clear", overflow, 0);
    wait_state(3'd2, 50, "abort_to_capture");
    for (int i = 0; i < 3; i++) adc_pulse(NB'(30 + i), 20);
    tx_q.delete();
    send_byte(8'hA5);
    chk("abort_state", state_o, 0);
    chk("abort_ena", adc_ena, 0);
    chk("abort_rstn", adc_rstn, 1);
    repeat (30) @(negedge clk);
    chk("abort_no_trailer", tx_q.size(), 0);
    chk("abort_cnt", cnt_captured, 3);

    // Clean run after abort
    send_byte(8'h55);
    chk("restart_cnt", cnt_captured, 0);
    tx_q.delete();
    wait_state(3'd2, 50, "restart_capture");
    for (int i = 0; i < NS; i++) adc_pulse(NB'(20 + i), 20);
    wait_state(3'd0, 200, "restart_done");
    chk("restart_nbytes", tx_q.size(), 9);
    if (tx_q.size() == 9) begin
      chk("restart_first", tx_q[0], 20);
      chk("restart_trailer", tx_q[8], 8'hAA);
    end
    chk("restart_ovf", overflow, 0);

    // Asynchronous reset mid-capture
    send_byte(8'h55);
    wait_state(3'd2, 50, "nrst_capture");
    adc_pulse(NB'(5), 10);
    adc_pulse(NB'(6), 10);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
